// File: rtl/u_ifu_fetch_ctrl_pkg.sv
// Shared IFU fetch definitions: packet width, fetch-controller state encoding
// and the sequential PC stride used by the PC generator.
package u_ifu_fetch_ctrl_pkg;

  localparam int IFU_PC_WIDTH    = 32;
  localparam int IFU_INST_WIDTH  = 32;
  localparam int FETCH_PKT_WIDTH = IFU_PC_WIDTH + 2 * IFU_INST_WIDTH;

  localparam logic [IFU_PC_WIDTH-1:0] PC_INCR = 32'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

endpackage

// File: rtl/u_ifu_fetch_fifo.sv
// Small synchronous decode FIFO with single-cycle flush and an occupancy count.
// Head data reads as zero whenever the FIFO is empty.
module u_ifu_fetch_fifo
  import u_ifu_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = FETCH_PKT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  output logic                         head_valid,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A flush wins over any same-cycle push or pop.
  assign head_valid = (count != '0);
  assign do_push    = push & ~flush & (count != FULL_CNT);
  assign do_pop     = pop & ~flush & head_valid;
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/u_ifu_fetch_ctrl.sv
// IFU fetch controller: owns the fetch PC, issues one outstanding 64-bit
// instruction fetch at a time and buffers responses toward decode.
module u_ifu_fetch_ctrl
  import u_ifu_fetch_ctrl_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_pulse,
  input  logic                      bru_flush,
  input  logic [PC_WIDTH-1:0]       arb_res_pc_q,
  input  logic                      is_pc_unalign,
  output logic [PC_WIDTH-1:0]       arb_res_pc,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [PC_WIDTH-1:0]       imem_req_addr,
  input  logic                      imem_rsp_valid,
  input  logic [2*INST_WIDTH-1:0]   imem_rsp_data,
  output logic                      dec_valid,
  input  logic                      dec_ready,
  output logic [PC_WIDTH-1:0]       dec_pc,
  output logic [INST_WIDTH-1:0]     dec_inst0,
  output logic [INST_WIDTH-1:0]     dec_inst1,
  output logic                      exc_unalign,
  output logic [PC_WIDTH-1:0]       exc_pc
);

  localparam int PKT_W = PC_WIDTH + 2 * INST_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  state_t              state;
  logic [PC_WIDTH-1:0] pc_inflight;
  logic [CNT_W-1:0]    fifo_count;
  logic [PKT_W-1:0]    head_data;
  logic                redirect;
  logic                req_accept;
  logic                rsp_push;

  // Only FETCH can issue, so no request is ever outstanding when the FIFO
  // gate is evaluated; count < depth alone guarantees room for the response.
  assign redirect       = start_pulse | bru_flush;
  assign imem_req_valid = (state == ST_FETCH) & ~is_pc_unalign & ~redirect &
                          (fifo_count < DEPTH_CNT);
  assign req_accept     = imem_req_valid & imem_req_ready;
  assign imem_req_addr  = arb_res_pc;
  assign rsp_push       = (state == ST_WAIT) & imem_rsp_valid & ~redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      arb_res_pc  <= '0;
      exc_unalign <= 1'b0;
      exc_pc      <= '0;
    end else begin
      if (redirect || req_accept) begin
        arb_res_pc <= arb_res_pc_q;
      end
      case (state)
        ST_IDLE: begin
          if (start_pulse) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (!redirect) begin
            if (is_pc_unalign) begin
              state       <= ST_HALT;
              exc_unalign <= 1'b1;
              exc_pc      <= arb_res_pc;
            end else if (req_accept) begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid)  state <= ST_FETCH;
          else if (redirect)   state <= ST_DRAIN;
        end
        // The outstanding response retires the drain even if a new redirect
        // lands in the same cycle; the PC has already been reloaded.
        ST_DRAIN: begin
          if (imem_rsp_valid) state <= ST_FETCH;
        end
        ST_HALT: begin
          if (redirect) begin
            state       <= ST_FETCH;
            exc_unalign <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (req_accept) begin
      pc_inflight <= arb_res_pc;
    end
  end

  u_ifu_fetch_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (rsp_push),
    .pop        (dec_ready),
    .push_data  ({pc_inflight, imem_rsp_data}),
    .head_valid (dec_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  assign dec_pc    = head_data[PKT_W-1 -: PC_WIDTH];
  assign dec_inst1 = head_data[2*INST_WIDTH-1 -: INST_WIDTH];
  assign dec_inst0 = head_data[INST_WIDTH-1:0];

endmodule

// File: tb/tb_u_ifu_fetch_ctrl.sv
// Directed bench for u_ifu_fetch_ctrl with a small PC-generator model and a
// variable-latency single-outstanding instruction memory model.
module tb_u_ifu_fetch_ctrl;
  import u_ifu_fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_pulse;
  logic        bru_flush;
  logic [31:0] arb_res_pc_q;
  logic        is_pc_unalign;
  logic [31:0] arb_res_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [63:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst0;
  logic [31:0] dec_inst1;
  logic        exc_unalign;
  logic [31:0] exc_pc;

  logic [31:0] start_pc;
  logic [31:0] flush_pc;
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          mem_lat;
  int          n_chk;
  int          n_pass;

  always #5 clk = ~clk;

  u_ifu_fetch_ctrl #(
    .PC_WIDTH   (32),
    .INST_WIDTH (32),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_pulse    (start_pulse),
    .bru_flush      (bru_flush),
    .arb_res_pc_q   (arb_res_pc_q),
    .is_pc_unalign  (is_pc_unalign),
    .arb_res_pc     (arb_res_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_inst0      (dec_inst0),
    .dec_inst1      (dec_inst1),
    .exc_unalign    (exc_unalign),
    .exc_pc         (exc_pc)
  );

  // PC generator: start, then flush, then sequential stride on accept.
  always_comb begin
    arb_res_pc_q  = arb_res_pc;
    is_pc_unalign = (arb_res_pc[1:0] != 2'b00);
    if (start_pulse)                          arb_res_pc_q = start_pc;
    else if (bru_flush)                       arb_res_pc_q = flush_pc;
    else if (imem_req_valid & imem_req_ready) arb_res_pc_q = arb_res_pc + PC_INCR;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // One clock: sample request acceptance, advance the memory model, clear pulses.
  task automatic cyc();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = imem_req_valid & imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    start_pulse = 1'b0;
    bru_flush   = 1'b0;
    if (imem_rsp_valid) pend = 1'b0;
    else if (pend)      pend_cnt--;
    if (acc) begin
      pend      = 1'b1;
      pend_cnt  = mem_lat;
      pend_addr = a;
    end
    imem_rsp_valid = pend && (pend_cnt == 1);
    imem_rsp_data  = {32'hB000_0000 | (pend_addr + 32'd4), 32'hA000_0000 | pend_addr};
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; start_pulse = 1'b0; bru_flush = 1'b0;
    start_pc = '0; flush_pc = '0; imem_req_ready = 1'b1; dec_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    pend = 1'b0; pend_cnt = 0; pend_addr = '0; mem_lat = 1;
    cyc(); cyc();
    check("rst_pc",       arb_res_pc, 32'h0);
    check("rst_req",      32'(imem_req_valid), 0);
    check("rst_dec_valid", 32'(dec_valid), 0);
    check("rst_exc",      32'(exc_unalign), 0);
    check("rst_dec_pc",   dec_pc, 32'h0);
    rst = 1'b0;

    start_pulse = 1'b1; start_pc = 32'h1000; #1;
    check("start_no_req", 32'(imem_req_valid), 0);
    cyc();
    #1;
    check("req0_valid", 32'(imem_req_valid), 1);
    check("req0_addr",  imem_req_addr, 32'h1000);
    cyc();
    #1;
    check("wait_no_req",  32'(imem_req_valid), 0);
    check("wait_dec_empty", 32'(dec_valid), 0);
    cyc();
    #1;
    check("pkt0_valid", 32'(dec_valid), 1);
    check("pkt0_pc",    dec_pc, 32'h1000);
    check("pkt0_inst0", dec_inst0, 32'hA000_1000);
    check("pkt0_inst1", dec_inst1, 32'hB000_1004);
    check("req1_valid", 32'(imem_req_valid), 1);
    check("req1_addr",  imem_req_addr, 32'h1008);
    cyc();
    #1;
    cyc();
    #1;
    check("full_no_req", 32'(imem_req_valid), 0);
    check("full_pc",     arb_res_pc, 32'h1010);
    cyc();
    #1;
    check("full_hold_no_req", 32'(imem_req_valid), 0);
    check("full_head_pc",     dec_pc, 32'h1000);
    dec_ready = 1'b1;
    cyc();
    dec_ready = 1'b0;
    #1;
    check("pop_head_pc", dec_pc, 32'h1008);
    check("resume_req",  32'(imem_req_valid), 1);
    check("resume_addr", imem_req_addr, 32'h1010);
    mem_lat = 3;
    cyc();

    bru_flush = 1'b1; flush_pc = 32'h2000; #1;
    check("flush_wait_no_req", 32'(imem_req_valid), 0);
    cyc();
    #1;
    check("drain_fifo_empty", 32'(dec_valid), 0);
    check("drain_pc",         arb_res_pc, 32'h2000);
    check("drain_no_req",     32'(imem_req_valid), 0);
    cyc();
    #1;
    check("drain_rsp_no_req", 32'(imem_req_valid), 0);
    cyc();
    #1;
    check("stale_dropped",  32'(dec_valid), 0);
    check("refetch_valid",  32'(imem_req_valid), 1);
    check("refetch_addr",   imem_req_addr, 32'h2000);
    mem_lat = 1;
    cyc();

    bru_flush = 1'b1; flush_pc = 32'h2000;
    cyc();
    #1;
    check("coinc_no_push", 32'(dec_valid), 0);
    check("coinc_req",     32'(imem_req_valid), 1);
    check("coinc_addr",    imem_req_addr, 32'h2000);
    cyc();
    #1;
    cyc();
    #1;
    check("pkt2k_valid", 32'(dec_valid), 1);
    check("pkt2k_pc",    dec_pc, 32'h2000);
    check("pkt2k_inst0", dec_inst0, 32'hA000_2000);

    bru_flush = 1'b1; flush_pc = 32'h3002;
    cyc();
    #1;
    check("unalign_no_req",  32'(imem_req_valid), 0);
    check("unalign_flushed", 32'(dec_valid), 0);
    cyc();
    #1;
    check("halt_exc",    32'(exc_unalign), 1);
    check("halt_exc_pc", exc_pc, 32'h3002);
    check("halt_no_req", 32'(imem_req_valid), 0);
    cyc();
    #1;
    check("halt_hold_no_req", 32'(imem_req_valid), 0);
    bru_flush = 1'b1; flush_pc = 32'h3000;
    cyc();
    #1;
    check("unhalt_exc_clr", 32'(exc_unalign), 0);
    check("unhalt_req",     32'(imem_req_valid), 1);
    check("unhalt_addr",    imem_req_addr, 32'h3000);
    cyc();

    start_pulse = 1'b1; start_pc = 32'h4000;
    bru_flush   = 1'b1; flush_pc = 32'h5000;
    #1;
    check("both_no_req", 32'(imem_req_valid), 0);
    cyc();
    #1;
    check("start_prio_addr",  imem_req_addr, 32'h4000);
    check("start_prio_req",   32'(imem_req_valid), 1);
    check("start_prio_empty", 32'(dec_valid), 0);
    mem_lat = 3;
    cyc();
    #1;
    check("pre_rst_pc", arb_res_pc, 32'h4008);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("mid_rst_pc",     arb_res_pc, 32'h0);
    check("mid_rst_req",    32'(imem_req_valid), 0);
    check("mid_rst_dec",    32'(dec_valid), 0);
    check("mid_rst_exc",    32'(exc_unalign), 0);
    check("mid_rst_exc_pc", exc_pc, 32'h0);
    check("mid_rst_dec_pc", dec_pc, 32'h0);
    cyc();
    #1;
    cyc();
    #1;
    check("idle_stale_drop", 32'(dec_valid), 0);
    check("idle_no_req",     32'(imem_req_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/u_ifu_fetch_ctrl.md
Name: u_ifu_fetch_ctrl

Overview:
- IFU fetch controller, directly downstream of the PC generator.
- Owns the architectural fetch-PC register and feeds it back to the generator as arb_res_pc.
- Issues 64-bit (dual 32-bit instruction) instruction-memory requests with at most one outstanding, and buffers responses in a 2-entry FIFO toward decode.
- Handles start, branch-redirect flush, stale-response drop and PC-unalignment halt.

Parameters:
- PC_WIDTH, 32, fetch PC width (matches `PC_WIDTH).
- INST_WIDTH, 32, single instruction width; the fetch packet is 2*INST_WIDTH.
- FIFO_DEPTH, 2, decode buffer entries. Fixed at 2; other values are unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_pulse  in  1  start fetch; has priority over bru_flush
- bru_flush  in  1  branch redirect / flush
- arb_res_pc_q  in  PC_WIDTH  next PC from the PC generator
- is_pc_unalign  in  1  unalignment flag for the current arb_res_pc, from the PC generator
- arb_res_pc  out  PC_WIDTH  current fetch PC register, returned to the PC generator
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts the request
- imem_req_addr  out  PC_WIDTH  equals arb_res_pc
- imem_rsp_valid  in  1  response strobe; latency of one or more cycles, in order
- imem_rsp_data  in  2*INST_WIDTH  [31:0] = inst at PC, [63:32] = inst at PC+4
- dec_valid  out  1  FIFO head valid
- dec_ready  in  1  decode pops the head
- dec_pc  out  PC_WIDTH  PC of the head packet
- dec_inst0  out  INST_WIDTH  head instruction 0
- dec_inst1  out  INST_WIDTH  head instruction 1
- exc_unalign  out  1  sticky unaligned-fetch exception
- exc_pc  out  PC_WIDTH  the offending PC

Behaviour:
- Reset values:
  - arb_res_pc = 0; state = IDLE.
  - FIFO empty, so dec_valid = 0.
  - exc_unalign = 0; exc_pc = 0.
  - imem_req_valid = 0; dec_pc, dec_inst0 and dec_inst1 = 0.
- States: IDLE, FETCH, WAIT, DRAIN, HALT.
- PC register:
  - arb_res_pc <= arb_res_pc_q when start_pulse, or bru_flush, or (imem_req_valid & imem_req_ready).
  - Otherwise arb_res_pc holds. The PC generator supplies the priority: start, then flush, then PC+8.
- Request rule: imem_req_valid = (state==FETCH) & ~is_pc_unalign & ~start_pulse & ~bru_flush & (fifo_count < 2).
- The in-flight packet PC is captured into pc_inflight on request accept.
- Transitions:
  - IDLE: start_pulse -> FETCH. bru_flush alone is ignored.
  - FETCH:
    - start_pulse or bru_flush -> FETCH; the PC is reloaded.
    - Else is_pc_unalign -> HALT; set exc_unalign = 1 and exc_pc = arb_res_pc.
    - Else request accepted -> WAIT.
  - WAIT:
    - start_pulse or bru_flush -> DRAIN if no imem_rsp_valid that cycle. If imem_rsp_valid, the response is discarded and the state goes to FETCH.
    - Else imem_rsp_valid -> push {pc_inflight, rsp_data} and go to FETCH.
  - DRAIN: imem_rsp_valid -> discard and go to FETCH. Start or flush keeps DRAIN and reloads the PC.
  - HALT: no requests. start_pulse or bru_flush -> FETCH, clear exc_unalign, reload the PC.
- FIFO:
  - Push and pop may happen in the same cycle.
  - A push never occurs when full. This is guaranteed by the count<2 gate, which counts the outstanding request: the gate condition is fifo_count + (state==WAIT) < 2, evaluated in FETCH.
  - start_pulse or bru_flush empties the FIFO in that cycle. A same-cycle push or pop is dropped.
- Latency: the first request occurs the cycle after start_pulse. With a 1-cycle memory, dec_valid rises 2 cycles after the request is accepted (push, then registered head).
- Throughput: one packet per 2 cycles minimum; it is limited by the single outstanding request.
- rst mid-WAIT: any later stale response is ignored only if it arrives while state is IDLE (IDLE discards all rsp). The memory must also be reset.

Decomposition:
- Shared ifu package/header holds:
  - FETCH_PKT_WIDTH = PC_WIDTH + 2*INST_WIDTH;
  - state encodings (IDLE=0, FETCH=1, WAIT=2, DRAIN=3, HALT=4, 3-bit);
  - the PC increment constant 8.
- One sub-module: u_ifu_fetch_fifo (2-entry synchronous FIFO with flush, count output).

Test Plan:
- Reset, then start_pulse with start_pc 0x1000 and a 1-cycle memory returning data D -> requests at 0x1000, 0x1008, 0x1010. dec_pc = 0x1000 with inst0 = D[31:0] and inst1 = D[63:32].
- dec_ready held 0 -> exactly 2 packets are buffered. imem_req_valid stays 0 until a pop, then resumes at 0x1010.
- bru_flush to 0x2000 while in WAIT, with the response delayed 3 cycles -> the stale response is discarded. The FIFO is empty after the flush, and the next request is 0x2000 after the response arrives (DRAIN to FETCH).
- bru_flush coincident with imem_rsp_valid -> no push. The next request is 0x2000 in the following cycle.
- Redirect to 0x3002 -> no request is issued; exc_unalign = 1 and exc_pc = 0x3002. A later bru_flush to 0x3000 clears exc_unalign and fetches 0x3000.
- start_pulse (0x4000) and bru_flush (0x5000) in the same cycle -> the next request is 0x4000. rst asserted mid-WAIT -> all outputs return to their reset values the next cycle.
